// File: rtl/coord_pkg.sv
// rtl/coord_pkg.sv - shared encodings, element sizing and sequencer states
package coord_pkg;

    localparam logic [2:0] FMT_U8    = 3'd0;
    localparam logic [2:0] FMT_S8    = 3'd1;
    localparam logic [2:0] FMT_U16   = 3'd2;
    localparam logic [2:0] FMT_S16   = 3'd3;
    localparam logic [2:0] FMT_FLOAT = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    // Bytes occupied by one packed element; illegal codes are treated as FLOAT.
    function automatic logic [2:0] elem_size(input logic [2:0] fmt);
        case (fmt)
            FMT_U8, FMT_S8:   elem_size = 3'd1;
            FMT_U16, FMT_S16: elem_size = 3'd2;
            default:          elem_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/coord_elem_unpack.sv
// rtl/coord_elem_unpack.sv - extracts one big-endian element from a word, right-aligned
module coord_elem_unpack (
    input  logic [31:0] buf_word,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    output logic [31:0] elem
);

    logic [31:0] shifted;

    // Move the addressed byte to the MSB, then keep the top size bytes zero-extended.
    always_comb begin
        shifted = buf_word << {offset, 3'b000};
        case (size)
            3'd1:    elem = {24'd0, shifted[31:24]};
            3'd2:    elem = {16'd0, shifted[31:16]};
            default: elem = shifted;
        endcase
    end

endmodule

// File: rtl/coord_attr_sequencer.sv
// rtl/coord_attr_sequencer.sv - feeds attribute components through the shared coordinate converter
module coord_attr_sequencer
    import coord_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_format,
    input  logic [1:0]  cmd_count,
    input  logic [4:0]  cmd_shift,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        conv_start,
    output logic [31:0] conv_data,
    output logic [2:0]  conv_format,
    output logic [4:0]  conv_shift,
    input  logic        conv_valid,
    input  logic [31:0] conv_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_index,
    output logic        out_last,
    output logic        err_fmt,
    output logic        err_count
);

    state_t      state_q, state_d;
    logic [2:0]  fmt_q;
    logic [1:0]  count_q;
    logic [4:0]  shift_q;
    logic [31:0] buf_q;
    logic [1:0]  offset_q;
    logic [1:0]  index_q;
    logic [31:0] out_data_q;
    logic        err_fmt_q;
    logic        err_count_q;

    logic [2:0]  size;
    logic [3:0]  next_off;
    logic        next_fits;
    logic        is_last;

    assign size      = elem_size(fmt_q);
    assign next_off  = {2'b00, offset_q} + {1'b0, size};
    assign next_fits = (next_off + {1'b0, size}) <= 4'd4;
    assign is_last   = (index_q == (count_q - 2'd1));

    coord_elem_unpack u_unpack (
        .buf_word (buf_q),
        .offset   (offset_q),
        .size     (size),
        .elem     (conv_data)
    );

    assign conv_format = fmt_q;
    assign conv_shift  = shift_q;
    assign out_data    = out_data_q;
    assign out_index   = index_q;
    assign out_last    = (state_q == OUT) && is_last;
    assign err_fmt     = err_fmt_q;
    assign err_count   = err_count_q;

    // Next-state and handshake decode; one converter transaction in flight at most.
    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        conv_start = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_count != 2'd0)) state_d = FETCH;
            end
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ISSUE;
            end
            ISSUE: begin
                conv_start = 1'b1;
                state_d    = conv_valid ? OUT : WAIT;
            end
            WAIT: begin
                if (conv_valid) state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (is_last)        state_d = IDLE;
                    else if (next_fits) state_d = ISSUE;
                    else                state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, command latch, word buffer, result capture and sticky error flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            fmt_q       <= FMT_FLOAT;
            count_q     <= 2'd0;
            shift_q     <= 5'd0;
            buf_q       <= 32'd0;
            offset_q    <= 2'd0;
            index_q     <= 2'd0;
            out_data_q  <= 32'd0;
            err_fmt_q   <= 1'b0;
            err_count_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_valid) begin
                fmt_q   <= (cmd_format > FMT_FLOAT) ? FMT_FLOAT : cmd_format;
                count_q <= cmd_count;
                shift_q <= cmd_shift;
                index_q <= 2'd0;
                if (cmd_format > FMT_FLOAT) err_fmt_q   <= 1'b1;
                if (cmd_count == 2'd0)      err_count_q <= 1'b1;
            end
            if (state_q == FETCH && in_valid) begin
                buf_q    <= in_data;
                offset_q <= 2'd0;
            end
            if ((state_q == ISSUE || state_q == WAIT) && conv_valid) begin
                out_data_q <= conv_result;
            end
            if (state_q == OUT && out_ready && !is_last) begin
                index_q  <= index_q + 2'd1;
                offset_q <= next_off[1:0];
            end
        end
    end

endmodule

// File: tb/tb_coord_attr_sequencer.sv
// tb/tb_coord_attr_sequencer.sv - directed scoreboard bench for coord_attr_sequencer
module tb_coord_attr_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_format = 3'd0;
    logic [1:0]  cmd_count = 2'd0;
    logic [4:0]  cmd_shift = 5'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        conv_start;
    logic [31:0] conv_data;
    logic [2:0]  conv_format;
    logic [4:0]  conv_shift;
    logic        conv_valid;
    logic [31:0] conv_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [1:0]  out_index;
    logic        out_last;
    logic        err_fmt;
    logic        err_count;

    always #5 clk = ~clk;

    coord_attr_sequencer dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_format  (cmd_format),
        .cmd_count   (cmd_count),
        .cmd_shift   (cmd_shift),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .conv_start  (conv_start),
        .conv_data   (conv_data),
        .conv_format (conv_format),
        .conv_shift  (conv_shift),
        .conv_valid  (conv_valid),
        .conv_result (conv_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .err_fmt     (err_fmt),
        .err_count   (err_count)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  idx;
        logic        last;
    } out_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  fmt;
        logic [4:0]  shift;
    } conv_exp_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    out_exp_t    out_q[$];
    conv_exp_t   conv_q[$];
    logic [31:0] words_q[$];
    int          in_hs = 0;
    int          cstart_cnt = 0;
    logic        seen_in_ready = 1'b0;
    logic        seen_out_valid = 1'b0;

    int          lat = 0;
    logic        inj = 1'b0;
    logic        pend = 1'b0;
    int          rem = 0;
    logic        cv_r = 1'b0;
    logic [31:0] res_r = 32'd0;
    logic [31:0] held_data = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] to_float(input logic signed [31:0] v, input logic [4:0] sh);
        logic [31:0] mag;
        logic [7:0]  e;
        logic [22:0] mant;
        int          p;
        if (v == 0) return 32'd0;
        mag = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        e    = 8'(127 + p - int'(sh));
        mant = 23'(mag << (23 - p));
        return {(v < 0), e, mant};
    endfunction

    function automatic logic [31:0] conv_model(input logic [2:0] f, input logic [4:0] sh, input logic [31:0] d);
        case (f)
            3'd0:    return to_float({24'd0, d[7:0]}, sh);
            3'd1:    return to_float({{24{d[7]}}, d[7:0]}, sh);
            3'd2:    return to_float({16'd0, d[15:0]}, sh);
            3'd3:    return to_float({{16{d[15]}}, d[15:0]}, sh);
            default: return d;
        endcase
    endfunction

    // Converter stand-in: same-cycle answer for lat==0, otherwise lat cycles after the start pulse.
    always_comb begin
        conv_valid  = cv_r | inj;
        conv_result = inj ? 32'hDEADBEEF : res_r;
        if (lat == 0 && conv_start) begin
            conv_valid  = 1'b1;
            conv_result = conv_model(conv_format, conv_shift, conv_data);
        end
    end

    always @(negedge clk) begin
        if (pend && !conv_start && !cmd_ready && !out_valid)
            check("conv_data_stable", conv_data, held_data);
        if (conv_start) begin
            cstart_cnt++;
            if (lat > 0) begin
                pend      = 1'b1;
                rem       = lat - 1;
                res_r     = conv_model(conv_format, conv_shift, conv_data);
                held_data = conv_data;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        cv_r = 1'b0;
        if (pend) begin
            if (rem == 0) begin
                cv_r = 1'b1;
                pend = 1'b0;
            end else begin
                rem--;
            end
        end
    end

    // Raw word source.
    always @(posedge clk) begin
        #1;
        if (words_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = words_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = 32'd0;
        end
    end

    // Monitors: input handshakes, converter issues and output handshakes against the scoreboards.
    always @(negedge clk) begin
        if (in_ready) seen_in_ready = 1'b1;
        if (out_valid) seen_out_valid = 1'b1;
        if (resetn && in_valid && in_ready) begin
            void'(words_q.pop_front());
            in_hs++;
        end
        if (conv_start) begin
            if (conv_q.size() == 0) begin
                check("conv_expected", 32'(conv_q.size()), 32'd1);
            end else begin
                conv_exp_t c;
                c = conv_q.pop_front();
                check("conv_data", conv_data, c.data);
                check("conv_format", 32'(conv_format), 32'(c.fmt));
                check("conv_shift", 32'(conv_shift), 32'(c.shift));
            end
        end
        if (resetn && out_valid && out_ready) begin
            if (out_q.size() == 0) begin
                check("out_expected", 32'(out_q.size()), 32'd1);
            end else begin
                out_exp_t o;
                o = out_q.pop_front();
                check("out_data", out_data, o.data);
                check("out_index", 32'(out_index), 32'(o.idx));
                check("out_last", 32'(out_last), 32'(o.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_conv(input logic [31:0] d, input logic [2:0] f, input logic [4:0] s);
        conv_q.push_back('{d, f, s});
    endtask

    task automatic push_out(input logic [31:0] d, input logic [1:0] i, input logic l);
        out_q.push_back('{d, i, l});
    endtask

    task automatic send_cmd(input logic [2:0] f, input logic [1:0] c, input logic [4:0] s);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        cmd_valid  = 1'b1;
        cmd_format = f;
        cmd_count  = c;
        cmd_shift  = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Cycles from the command cycle to the first out_valid cycle; call right after send_cmd.
    task automatic measure_lat(output int l);
        l = 1;
        while (l < 50) begin
            @(negedge clk);
            if (out_valid) break;
            l++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(cmd_ready && out_q.size() == 0 && conv_q.size() == 0) && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(cmd_ready && out_q.size() == 0 && conv_q.size() == 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;
        int h0;
        int cs0;

        resetn = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_conv_start", 32'(conv_start), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_err_fmt", 32'(err_fmt), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // FLOAT x3, converter answers in the issue cycle.
        lat = 0;
        h0 = in_hs;
        words_q.push_back(32'h3F800000);
        words_q.push_back(32'h40000000);
        words_q.push_back(32'hC0400000);
        push_conv(32'h3F800000, 3'd4, 5'd0);
        push_conv(32'h40000000, 3'd4, 5'd0);
        push_conv(32'hC0400000, 3'd4, 5'd0);
        push_out(32'h3F800000, 2'd0, 1'b0);
        push_out(32'h40000000, 2'd1, 1'b0);
        push_out(32'hC0400000, 2'd2, 1'b1);
        send_cmd(3'd4, 2'd3, 5'd0);
        measure_lat(l);
        check("lat_float", 32'(l), 32'd3);
        wait_idle("idle_float");
        check("words_float", 32'(in_hs - h0), 32'd3);

        // S8 x3 from one word, trailing byte discarded.
        h0 = in_hs;
        words_q.push_back(32'h01FF7F80);
        push_conv(32'h00000001, 3'd1, 5'd0);
        push_conv(32'h000000FF, 3'd1, 5'd0);
        push_conv(32'h0000007F, 3'd1, 5'd0);
        push_out(32'h3F800000, 2'd0, 1'b0);
        push_out(32'hBF800000, 2'd1, 1'b0);
        push_out(32'h42FE0000, 2'd2, 1'b1);
        send_cmd(3'd1, 2'd3, 5'd0);
        wait_idle("idle_s8");
        check("words_s8", 32'(in_hs - h0), 32'd1);
        check("words_left_s8", 32'(words_q.size()), 32'd0);

        // U16 with shift 4, converter latency 2, downstream stalled for 5 cycles.
        lat = 2;
        out_ready = 1'b0;
        h0 = in_hs;
        words_q.push_back(32'h00100020);
        words_q.push_back(32'h0030ABCD);
        push_conv(32'h00000010, 3'd2, 5'd4);
        push_conv(32'h00000020, 3'd2, 5'd4);
        push_conv(32'h00000030, 3'd2, 5'd4);
        push_out(32'h3F800000, 2'd0, 1'b0);
        push_out(32'h40000000, 2'd1, 1'b0);
        push_out(32'h40400000, 2'd2, 1'b1);
        send_cmd(3'd2, 2'd3, 5'd4);
        measure_lat(l);
        check("lat_u16_l2", 32'(l), 32'd5);
        cs0 = cstart_cnt;
        repeat (5) @(negedge clk);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_out_data", out_data, 32'h3F800000);
        check("stall_out_index", 32'(out_index), 32'd0);
        check("stall_no_conv_start", 32'(cstart_cnt - cs0), 32'd0);
        tick();
        out_ready = 1'b1;
        wait_idle("idle_u16");
        check("words_u16", 32'(in_hs - h0), 32'd2);
        lat = 0;

        // Stray conv_valid while idle.
        seen_out_valid = 1'b0;
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        repeat (3) tick();
        check("stray_conv_no_out", 32'(seen_out_valid), 32'd0);
        check("stray_conv_idle", 32'(cmd_ready), 32'd1);

        // Illegal format is converted as FLOAT and flagged.
        words_q.push_back(32'h12345678);
        push_conv(32'h12345678, 3'd4, 5'd0);
        push_out(32'h12345678, 2'd0, 1'b1);
        send_cmd(3'd6, 2'd1, 5'd0);
        wait_idle("idle_badfmt");
        check("err_fmt_set", 32'(err_fmt), 32'd1);
        check("err_count_clear", 32'(err_count), 32'd0);

        // Zero count: flagged, nothing consumed.
        seen_in_ready = 1'b0;
        h0 = in_hs;
        send_cmd(3'd0, 2'd0, 5'd0);
        @(negedge clk);
        check("cnt0_cmd_ready", 32'(cmd_ready), 32'd1);
        check("cnt0_err_count", 32'(err_count), 32'd1);
        repeat (3) tick();
        check("cnt0_no_in_ready", 32'(seen_in_ready), 32'd0);
        check("cnt0_words", 32'(in_hs - h0), 32'd0);

        // Reset while waiting on a slow converter.
        lat = 3;
        words_q.push_back(32'hAAAA5555);
        push_conv(32'hAAAA5555, 3'd4, 5'd0);
        send_cmd(3'd4, 2'd1, 5'd0);
        l = 0;
        while (l < 50) begin
            @(negedge clk);
            if (conv_start) break;
            l++;
        end
        check("mid_reset_issued", 32'(conv_start), 32'd1);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_conv_start", 32'(conv_start), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_err_fmt", 32'(err_fmt), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        seen_out_valid = 1'b0;
        repeat (6) tick();
        check("mid_rst_late_valid_ignored", 32'(seen_out_valid), 32'd0);
        lat = 0;

        check("out_q_drained", 32'(out_q.size()), 32'd0);
        check("conv_q_drained", 32'(conv_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/coord_attr_sequencer.md
Name: coord_attr_sequencer

Overview:
Sequences one vertex attribute (1–3 components) through the shared coordinate-to-float converter. Unpacks big-endian packed raw elements from a 32-bit input word stream and issues one component per converter transaction. Captures each float result and presents it on a valid/ready output with a component index. Sits between the vertex fetch stream and the transform unit; it is the converter's only requester.

Parameters:
None. All widths are fixed by the converter interface.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
cmd_valid  in  1  attribute command valid
cmd_ready  out  1  command accepted; high only in IDLE
cmd_format  in  3  0=U8 1=S8 2=U16 3=S16 4=FLOAT; 5–7 illegal
cmd_count  in  2  components 1..3; 0 illegal
cmd_shift  in  5  fractional shift passed to converter
in_valid  in  1  raw word valid
in_ready  out  1  raw word accept; high only in FETCH
in_data  in  32  packed raw elements, first element in MSBs
conv_start  out  1  converter start pulse
conv_data  out  32  element, right-aligned, zero-extended
conv_format  out  3  format to converter
conv_shift  out  5  shift to converter
conv_valid  in  1  converter result valid; may coincide with conv_start for FLOAT
conv_result  in  32  converter float output
out_valid  out  1  converted component valid
out_ready  in  1  downstream accept
out_data  out  32  float result
out_index  out  2  component index 0..2
out_last  out  1  final component of the attribute
err_fmt  out  1  sticky: illegal format seen
err_count  out  1  sticky: count 0 seen

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, out_valid=0, conv_start=0, err_*=0, byte offset=0, index=0. Data outputs are don't-care. Reset in any state aborts the attribute; no partial output follows.
- Element size: U8/S8=1 byte, U16/S16=2 bytes, FLOAT=4 bytes. Formats 5–7 set err_fmt and are processed as FLOAT (conv_format=4).
- IDLE: cmd_ready=1. On cmd_valid, latch format, count and shift, and set index=0.
  - count=0: set err_count and stay in IDLE. No input is consumed and no output is produced.
  - Otherwise go to FETCH.
- FETCH: in_ready=1. On in_valid, latch the word into buf, set offset=0, and go to ISSUE.
- ISSUE (1 cycle): conv_start=1.
  - conv_data = buf bytes [offset .. offset+size-1], counted from the MSB, placed in the LSBs.
  - conv_data, conv_format and conv_shift stay stable from ISSUE until the result is captured.
  - If conv_valid is high this cycle, capture and go to OUT; else go to WAIT.
- WAIT: conv_start=0. On conv_valid, capture conv_result into out_data and go to OUT. conv_valid in any other state is ignored.
- OUT: out_valid=1 and out_data, out_index, out_last are held stable. out_last = (index==count-1). On out_ready:
  - If last: go to IDLE. Unused bytes of buf are discarded; every attribute starts on a word boundary.
  - Else: index+=1 and offset+=size. If offset+size ≤ 4, go to ISSUE; else go to FETCH.
- No overlap: at most one converter transaction is outstanding, and no new conv_start is issued while out_valid is pending.
- Latency, cmd accept to first out_valid (zero-wait input):
  - FLOAT: 3 cycles (cmd, FETCH, ISSUE → OUT).
  - Converter latency L: 3+L cycles.
- Words consumed per attribute = ceil(count*size/4). Examples: 3×U8=1, 3×S16=2, 3×FLOAT=3.

Decomposition:
- Package coord_pkg holds:
  - format encodings FMT_U8..FMT_FLOAT;
  - function elem_size(format);
  - state enum IDLE/FETCH/ISSUE/WAIT/OUT.
- Sub-module coord_elem_unpack (combinational): takes buf, offset and size, and produces the right-aligned element.

Test Plan:
- FLOAT: cmd fmt=4 count=3 shift=0; words 0x3F800000, 0x40000000, 0xC0400000 → out_data equals each word; index 0, 1, 2; out_last only on index 2; 3 input handshakes.
- S8: fmt=1 count=3; word 0x01FF7F80 → conv_data 0x01, 0xFF, 0x7F; 1 input handshake; byte 0x80 discarded. With real converter, first out_data=0x3F800000.
- U16 with shift: fmt=2 count=3 shift=4; words 0x00100020, 0x0030ABCD → conv_data 0x0010, 0x0020, 0x0030; conv_shift=4 on each; 2 words consumed; 0xABCD discarded.
- Backpressure and latency: out_ready low 5 cycles after first out_valid → outputs stable, no conv_start meanwhile. Converter model with L=2 → conv_data stable from ISSUE through WAIT. conv_valid pulsed in IDLE → ignored.
- Errors: fmt=6 count=1 word 0x12345678 → err_fmt=1, conv_format=4, out_data=0x12345678. cmd count=0 → err_count=1, cmd_ready back high next cycle, in_ready never asserted.
- Reset mid-op: resetn low during WAIT → next cycle out_valid=0, conv_start=0, cmd_ready=1, err_*=0; a later conv_valid is ignored.
